// File: rtl/bus_decoder.sv
// rtl/bus_decoder.sv - CPU data bus address decoder and slave response mux
//
// Purpose:
//   Decodes each master request against NSLAVE address windows, pulses the
//   enable of the selected slave, waits for that slave's ready and muxes its
//   read data back to the master. Unmapped addresses and slaves that stay
//   silent for TIMEOUT cycles get a one-cycle error response carrying
//   ERR_VALUE. One request is outstanding at a time; a new request may be
//   accepted in the same cycle the previous one completes.
//
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   m_enable_i      master request valid (held by master until accepted)
//   m_wstrb_i       byte write strobes, 0 = read
//   m_addr_i        request address
//   m_wvalue_i      write data
//   m_rvalue_o      read data, valid with m_ready_o
//   m_ready_o       one-cycle completion pulse
//   m_err_o         qualifies m_ready_o: decode miss or timeout
//   s_enable_o      one-hot request pulse to the selected slave
//   s_wstrb_o       broadcast of m_wstrb_i
//   s_addr_o        broadcast of m_addr_i
//   s_wvalue_o      broadcast of m_wvalue_i
//   s_rvalue_i      packed slave read data, slot i = slave i
//   s_ready_i       slave i response valid

module bus_decoder #(
  parameter int unsigned          NSLAVE    = 4,
  parameter logic [NSLAVE*32-1:0] BASE      = '0,
  parameter logic [NSLAVE*32-1:0] MASK      = '0,
  parameter int unsigned          TIMEOUT   = 15,
  parameter logic [31:0]          ERR_VALUE = 32'hDEADBEEF
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 m_enable_i,
  input  logic [3:0]           m_wstrb_i,
  input  logic [31:0]          m_addr_i,
  input  logic [31:0]          m_wvalue_i,
  output logic [31:0]          m_rvalue_o,
  output logic                 m_ready_o,
  output logic                 m_err_o,
  output logic [NSLAVE-1:0]    s_enable_o,
  output logic [3:0]           s_wstrb_o,
  output logic [31:0]          s_addr_o,
  output logic [31:0]          s_wvalue_o,
  input  logic [NSLAVE*32-1:0] s_rvalue_i,
  input  logic [NSLAVE-1:0]    s_ready_i
);

  localparam int SW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] sel, sel_n;
  logic [CW-1:0] cnt, cnt_n;

  logic          hit;
  logic [SW-1:0] hit_idx;
  logic          sel_ready;
  logic          resp;
  logic          accept;

  // Scan from the top down so the lowest matching index is the one left
  // standing when windows overlap.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if ((m_addr_i & MASK[i*32 +: 32]) == BASE[i*32 +: 32]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  assign sel_ready = (state == ST_WAIT) && s_ready_i[sel];
  assign resp      = sel_ready || (state == ST_ERR);

  // Gating with rstn_i keeps the slave enables quiet while reset is held,
  // since accept is otherwise purely combinational on the master inputs.
  assign accept = rstn_i && m_enable_i && ((state == ST_IDLE) || resp);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= ST_IDLE;
      sel   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    if (accept) begin
      if (hit) begin
        state_n = ST_WAIT;
        sel_n   = hit_idx;
        cnt_n   = '0;
      end else begin
        state_n = ST_ERR;
      end
    end else if (resp) begin
      state_n = ST_IDLE;
    end else if (state == ST_WAIT) begin
      // Reaching here means no ready this cycle; ready on the last
      // allowed cycle is handled by the resp branch above and wins.
      if (cnt == CW'(TIMEOUT - 1)) begin
        state_n = ST_ERR;
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end
  end

  always_comb begin
    m_ready_o  = resp;
    m_err_o    = (state == ST_ERR);
    m_rvalue_o = '0;
    if (state == ST_ERR) begin
      m_rvalue_o = ERR_VALUE;
    end else if (sel_ready) begin
      m_rvalue_o = s_rvalue_i[sel*32 +: 32];
    end
  end

  always_comb begin
    s_enable_o = '0;
    if (accept && hit) begin
      s_enable_o[hit_idx] = 1'b1;
    end
  end

  assign s_wstrb_o  = m_wstrb_i;
  assign s_addr_o   = m_addr_i;
  assign s_wvalue_o = m_wvalue_i;

endmodule

// File: tb/tb_bus_decoder.sv
// tb/tb_bus_decoder.sv - scoreboard bench for bus_decoder
module tb_bus_decoder;

  localparam int NS = 3;

  logic            clk_i = 1'b0;
  logic            rstn_i = 1'b0;
  logic            m_enable_i = 1'b0;
  logic [3:0]      m_wstrb_i = '0;
  logic [31:0]     m_addr_i = '0;
  logic [31:0]     m_wvalue_i = '0;
  logic [31:0]     m_rvalue_o;
  logic            m_ready_o;
  logic            m_err_o;
  logic [NS-1:0]   s_enable_o;
  logic [3:0]      s_wstrb_o;
  logic [31:0]     s_addr_o;
  logic [31:0]     s_wvalue_o;
  logic [NS*32-1:0] s_rvalue_i;
  logic [NS-1:0]   s_ready_i = '0;
  logic [31:0]     srv [NS];

  assign s_rvalue_i = {srv[2], srv[1], srv[0]};

  // slave0: 0x0xxx_xxxx, slave1: 0x2/0x3xxx_xxxx, slave2: same window as slave0
  bus_decoder #(
    .NSLAVE   (NS),
    .BASE     ({32'h0000_0000, 32'h2000_0000, 32'h0000_0000}),
    .MASK     ({32'hF000_0000, 32'hE000_0000, 32'hF000_0000}),
    .TIMEOUT  (3),
    .ERR_VALUE(32'hDEADBEEF)
  ) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .m_enable_i(m_enable_i),
    .m_wstrb_i (m_wstrb_i),
    .m_addr_i  (m_addr_i),
    .m_wvalue_i(m_wvalue_i),
    .m_rvalue_o(m_rvalue_o),
    .m_ready_o (m_ready_o),
    .m_err_o   (m_err_o),
    .s_enable_o(s_enable_o),
    .s_wstrb_o (s_wstrb_o),
    .s_addr_o  (s_addr_o),
    .s_wvalue_o(s_wvalue_o),
    .s_rvalue_i(s_rvalue_i),
    .s_ready_i (s_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc_n = 0;
  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  typedef struct {
    int          at;
    logic [31:0] rv;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic expect_resp(input int at, input logic [31:0] rv, input logic err);
    resp_t e;
    e.at  = at;
    e.rv  = rv;
    e.err = err;
    exp_q.push_back(e);
  endtask

  // Monitor: every response pulse must match the head of the scoreboard,
  // and outside a response the data/err outputs must be zero.
  always @(negedge clk_i) begin : monitor
    resp_t e;
    if (m_ready_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: actual m_ready_o=1 rvalue=%h err=%b expected no response (cycle %0d)",
                 m_rvalue_o, m_err_o, cyc_n);
      end else begin
        e = exp_q.pop_front();
        chk("resp_cycle", 32'(cyc_n), 32'(e.at));
        chk("resp_rvalue", m_rvalue_o, e.rv);
        chk("resp_err", 32'(m_err_o), 32'(e.err));
      end
    end else begin
      chk("quiet_err", 32'(m_err_o), 32'h0);
      chk("quiet_rvalue", m_rvalue_o, 32'h0);
    end
  end

  // One bus cycle: drive at posedge+1, check slave side at negedge.
  task automatic cyc(input logic en, input logic [31:0] addr, input logic [3:0] ws,
                     input logic [NS-1:0] rdy, input logic [NS-1:0] exp_sen, input string name);
    m_enable_i = en;
    m_addr_i   = addr;
    m_wstrb_i  = ws;
    m_wvalue_i = ~addr;
    s_ready_i  = rdy;
    @(negedge clk_i);
    chk({name, "_sen"}, 32'(s_enable_o), 32'(exp_sen));
    if (en) begin
      chk({name, "_baddr"}, s_addr_o, addr);
      chk({name, "_bwval"}, s_wvalue_o, ~addr);
      chk({name, "_bwstrb"}, 32'(s_wstrb_o), 32'(ws));
    end
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0]   a3 [5];
  logic [NS-1:0] s3 [5];
  logic [3:0]    w3 [5];
  logic [31:0]   e3 [4];
  logic [NS-1:0] prev_rdy;

  initial begin
    for (int i = 0; i < NS; i++) srv[i] = '0;

    // Reset with a hitting request held: nothing may leave the decoder.
    m_enable_i = 1'b1;
    m_addr_i   = 32'h2000_0000;
    @(negedge clk_i);
    chk("reset_sen", 32'(s_enable_o), 32'h0);
    chk("reset_ready", 32'(m_ready_o), 32'h0);
    @(posedge clk_i);
    #1;
    m_enable_i = 1'b0;
    rstn_i = 1'b1;
    cyc(1'b0, 32'h0, 4'h0, 3'b000, 3'b000, "idle");

    // Read hit to slave 1, one-cycle slave.
    srv[1] = 32'hCAFEF00D;
    expect_resp(cyc_n + 1, 32'hCAFEF00D, 1'b0);
    cyc(1'b1, 32'h2000_0010, 4'h0, 3'b000, 3'b010, "hit");
    cyc(1'b0, 32'h0, 4'h0, 3'b010, 3'b000, "hit_rsp");
    cyc(1'b0, 32'h0, 4'h0, 3'b000, 3'b000, "hit_idle");

    // Back-to-back: four requests complete in four consecutive cycles.
    a3 = '{32'h2000_0000, 32'h2000_0004, 32'h0000_0100, 32'h3000_0008, 32'h0};
    s3 = '{3'b010, 3'b010, 3'b001, 3'b010, 3'b000};
    w3 = '{4'h0, 4'hF, 4'h0, 4'h3, 4'h0};
    e3 = '{32'hB000_0101, 32'hB000_0102, 32'hB000_0003, 32'hB000_0104};
    prev_rdy = '0;
    for (int k = 0; k <= 4; k++) begin
      for (int i = 0; i < NS; i++) srv[i] = 32'hB000_0000 | 32'(i << 8) | 32'(k);
      if (k < 4) expect_resp(cyc_n + 1, e3[k], 1'b0);
      cyc(k < 4, a3[k], w3[k], prev_rdy, s3[k], "b2b");
      prev_rdy = s3[k];
    end
    cyc(1'b0, 32'h0, 4'h0, 3'b000, 3'b000, "b2b_idle");

    // Decode miss, then a new request accepted in the error cycle.
    srv[1] = 32'h1234_5678;
    expect_resp(cyc_n + 1, 32'hDEADBEEF, 1'b1);
    cyc(1'b1, 32'hF000_0000, 4'h0, 3'b000, 3'b000, "miss");
    expect_resp(cyc_n + 1, 32'h1234_5678, 1'b0);
    cyc(1'b1, 32'h2000_0020, 4'h0, 3'b000, 3'b010, "miss_b2b");
    cyc(1'b0, 32'h0, 4'h0, 3'b010, 3'b000, "miss_b2b_rsp");
    cyc(1'b0, 32'h0, 4'h0, 3'b000, 3'b000, "miss_idle");

    // Timeout (TIMEOUT=3): error 4 cycles after accept; held request is
    // ignored during WAIT and accepted in the error cycle.
    srv[1] = 32'h5555_AAAA;
    srv[0] = 32'h0000_0BAD;
    expect_resp(cyc_n + 4, 32'hDEADBEEF, 1'b1);
    cyc(1'b1, 32'h2000_0000, 4'h0, 3'b000, 3'b010, "to_acc");
    cyc(1'b0, 32'h0, 4'h0, 3'b000, 3'b000, "to_w1");
    cyc(1'b1, 32'h2000_0100, 4'h0, 3'b000, 3'b000, "to_ign1");
    cyc(1'b1, 32'h2000_0100, 4'h0, 3'b000, 3'b000, "to_ign2");
    expect_resp(cyc_n + 3, 32'h5555_AAAA, 1'b0);
    cyc(1'b1, 32'h2000_0100, 4'h0, 3'b000, 3'b010, "to_err_acc");
    cyc(1'b0, 32'h0, 4'h0, 3'b001, 3'b000, "to_other_rdy");
    cyc(1'b0, 32'h0, 4'h0, 3'b000, 3'b000, "to_w2");
    cyc(1'b0, 32'h0, 4'h0, 3'b010, 3'b000, "to_last_rdy");
    cyc(1'b0, 32'h0, 4'h0, 3'b000, 3'b000, "to_idle");

    // Overlapping windows: slave 0 wins over slave 2; slave 2 ready ignored.
    srv[0] = 32'h0000_AAAA;
    srv[2] = 32'h2222_2222;
    expect_resp(cyc_n + 3, 32'h0000_AAAA, 1'b0);
    cyc(1'b1, 32'h0000_1000, 4'h0, 3'b000, 3'b001, "ovl");
    cyc(1'b0, 32'h0, 4'h0, 3'b100, 3'b000, "ovl_r2");
    cyc(1'b0, 32'h0, 4'h0, 3'b000, 3'b000, "ovl_w");
    cyc(1'b0, 32'h0, 4'h0, 3'b001, 3'b000, "ovl_r0");
    cyc(1'b0, 32'h0, 4'h0, 3'b000, 3'b000, "ovl_idle");

    // Reset mid-WAIT: transaction abandoned, late ready produces nothing.
    cyc(1'b1, 32'h2000_0000, 4'h0, 3'b000, 3'b010, "rst_acc");
    m_enable_i = 1'b1;
    s_ready_i  = 3'b000;
    rstn_i     = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_sen", 32'(s_enable_o), 32'h0);
    chk("rst_mid_ready", 32'(m_ready_o), 32'h0);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    cyc(1'b0, 32'h0, 4'h0, 3'b010, 3'b000, "rst_late_rdy");
    cyc(1'b0, 32'h0, 4'h0, 3'b000, 3'b000, "rst_idle");

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
